// File: rtl/temporal_pkg.sv
// Shared types and helpers for the binary-to-temporal encoder.
package temporal_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GRST = 2'd1,
        RUN  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ENC_RISING  = 2'd0,
        ENC_FALLING = 2'd1,
        ENC_PULSE   = 2'd2
    } enc_mode_e;

    // Any value at or above the cycle width never fires; the cycle width itself is the canonical form.
    function automatic int unsigned inf_val(input int unsigned width);
        return width;
    endfunction

endpackage

// File: rtl/gamma_counter.sv
// Tick counter for one gamma cycle: synchronous clear, count enable, registered last-tick flag.
module gamma_counter #(
    parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
    parameter int unsigned VAL_W             = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [VAL_W-1:0] o_tick,
    output logic [VAL_W-1:0] o_tick_nxt,
    output logic             o_last
);

    localparam logic [VAL_W-1:0] PRE_LAST = VAL_W'(GAMMA_CYCLE_WIDTH - 2);

    logic [VAL_W-1:0] r_tick;
    logic [VAL_W-1:0] w_tick_nxt;
    logic             r_last;
    logic             w_last_nxt;

    always_comb begin
        w_tick_nxt = r_tick;
        if (i_clr) begin
            w_tick_nxt = '0;
        end else if (i_en) begin
            w_tick_nxt = r_tick + VAL_W'(1);
        end
    end

    // Flag is registered one tick early so the last-tick output comes straight from a flop.
    assign w_last_nxt = !i_clr && i_en && (r_tick == PRE_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tick <= '0;
            r_last <= 1'b0;
        end else begin
            r_tick <= w_tick_nxt;
            r_last <= w_last_nxt;
        end
    end

    assign o_tick     = r_tick;
    assign o_tick_nxt = w_tick_nxt;
    assign o_last     = r_last;

endmodule

// File: rtl/temporal_encoder.sv
// Binary-to-temporal front end: one edge-encoded line per channel per gamma cycle,
// plus the gamma reset that clears the downstream comparator latches.
module temporal_encoder
    import temporal_pkg::*;
#(
    parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
    parameter int unsigned PULSE_WIDTH       = 8,
    parameter int unsigned NUM_CH            = 2,
    parameter int unsigned MODE              = 0,
    parameter int unsigned VAL_W             = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH*VAL_W-1:0] in_val,
    output logic                    gamma_rst,
    output logic [NUM_CH-1:0]       line,
    output logic [VAL_W-1:0]        tick,
    output logic                    cycle_done
);

    localparam enc_mode_e        ENC      = enc_mode_e'(MODE[1:0]);
    localparam logic [VAL_W-1:0] INF      = VAL_W'(inf_val(GAMMA_CYCLE_WIDTH));
    localparam logic             IDLE_LVL = (ENC == ENC_FALLING);

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic                    r_grst;
    logic [NUM_CH*VAL_W-1:0] r_val;
    logic [NUM_CH-1:0]       r_line;
    logic [NUM_CH-1:0]       w_line_nxt;
    logic [VAL_W-1:0]        w_tick;
    logic [VAL_W-1:0]        w_tick_nxt;
    logic                    w_last;
    logic                    w_accept;
    logic                    w_run_nxt;

    assign in_ready = !rst && ((r_state == IDLE) || ((r_state == RUN) && w_last));
    assign w_accept = in_valid && in_ready;

    gamma_counter #(
        .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH),
        .VAL_W             (VAL_W)
    ) u_gamma_counter (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clr      ((r_state != RUN) || w_last),
        .i_en       ((r_state == RUN) && !w_last),
        .o_tick     (w_tick),
        .o_tick_nxt (w_tick_nxt),
        .o_last     (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = GRST;
            GRST:    w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = w_accept ? GRST : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_run_nxt = (w_state_nxt == RUN);

    // Lines are computed from the upcoming state/tick so the registered line lines up with tick.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : gen_ch
        logic [VAL_W-1:0] w_v;
        logic [VAL_W-1:0] w_diff;
        logic             w_ge;
        logic             w_fire;

        assign w_v    = r_val[ch*VAL_W +: VAL_W];
        assign w_ge   = (w_tick_nxt >= w_v);
        assign w_diff = w_tick_nxt - w_v;
        assign w_fire = (ENC == ENC_PULSE) ? (w_ge && (32'(w_diff) < PULSE_WIDTH)) : w_ge;
        assign w_line_nxt[ch] = w_run_nxt ? (w_fire ^ IDLE_LVL) : IDLE_LVL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grst  <= 1'b0;
            r_val   <= {NUM_CH{INF}};
            r_line  <= {NUM_CH{IDLE_LVL}};
        end else begin
            r_state <= w_state_nxt;
            r_grst  <= (w_state_nxt == GRST);
            if (w_accept) begin
                r_val <= in_val;
            end
            r_line  <= w_line_nxt;
        end
    end

    assign gamma_rst  = rst || r_grst;
    assign line       = r_line;
    assign tick       = w_tick;
    assign cycle_done = w_last;

endmodule
